// File: rtl/mm_pkg.sv
// mm_pkg -- shared types and constants for the Mastermind turn-history block.
//   peg_t / guess_t : one peg colour, and a full guess (PEGS pegs, packed)
//   score_t         : black or white score count
//   hist_state_e    : history FSM states (EMPTY, PLAY, FULL)
//   MODE_PLAY/HIST  : encoding of the mode input
// The *_DEF constants are the default geometry used by mm_guess_history.
package mm_pkg;

    localparam int PEGS_DEF    = 4;
    localparam int COLOR_W_DEF = 3;
    localparam int TURNS_DEF   = 8;
    localparam int SW_DEF      = $clog2(PEGS_DEF + 1);

    typedef logic [COLOR_W_DEF-1:0] peg_t;
    typedef peg_t [PEGS_DEF-1:0]    guess_t;
    typedef logic [SW_DEF-1:0]      score_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PLAY  = 2'd1,
        FULL  = 2'd2
    } hist_state_e;

    localparam logic MODE_PLAY = 1'b0;
    localparam logic MODE_HIST = 1'b1;

endpackage

// File: rtl/mm_history_ram.sv
// mm_history_ram -- DEPTH x WIDTH turn store.
//   clk, reset : clock; asynchronous active-high clear of every entry
//   we, waddr, wdata : single write port
//   raddr      : read address
//   rd_zero    : when high the read register loads 0 instead of the entry
//   rdata      : registered read data (one cycle after raddr)
// Entries are plain registers because every one must be cleared by reset.
module mm_history_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic             rd_zero,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (rd_zero) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mm_guess_history.sv
// mm_guess_history -- turn-history buffer for the Mastermind datapath.
// Records each committed guess (and optionally its score) and lets the
// player browse earlier turns in history mode.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   mode                  0 = play (store), 1 = history (browse)
//   btn_select            pulse: commit guess (play mode, not full)
//   btn_up / btn_down     pulses: browse newer / older turn (history mode)
//   guess                 current guess, peg i at [i*COLOR_W +: COLOR_W]
//   selection             registered guess of selected_turn (0 when empty)
//   selected_turn         index of displayed turn
//   turn_count            stored guesses, 0..TURNS
//   last_turn             play mode and turn_count == TURNS-1
//   full                  turn_count == TURNS
// Optional feature, macro MM_HISTORY_SCORE_EN: adds score_black/score_white
// inputs stored with each guess and sel_black/sel_white outputs timed like
// selection.
module mm_guess_history
    import mm_pkg::*;
#(
    parameter int PEGS    = PEGS_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int TURNS   = TURNS_DEF,
    parameter int GW      = PEGS * COLOR_W,
    parameter int TW      = $clog2(TURNS),
    parameter int CW      = $clog2(TURNS + 1)
`ifdef MM_HISTORY_SCORE_EN
    ,
    parameter int SW      = $clog2(PEGS + 1)
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic          btn_select,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic [GW-1:0] guess,
`ifdef MM_HISTORY_SCORE_EN
    input  logic [SW-1:0] score_black,
    input  logic [SW-1:0] score_white,
    output logic [SW-1:0] sel_black,
    output logic [SW-1:0] sel_white,
`endif
    output logic [GW-1:0] selection,
    output logic [TW-1:0] selected_turn,
    output logic [CW-1:0] turn_count,
    output logic          last_turn,
    output logic          full
);

`ifdef MM_HISTORY_SCORE_EN
    localparam int DW = GW + 2 * SW;
`else
    localparam int DW = GW;
`endif

    hist_state_e   state_reg, state_next;
    logic [CW-1:0] turn_count_reg, turn_count_next;
    logic [TW-1:0] selected_turn_reg, selected_turn_next;
    logic          last_turn_reg, full_reg;

    logic          store;
    logic          browse;
    logic [TW-1:0] newest_turn;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    // Index of the most recent stored turn (0 while nothing is stored).
    assign newest_turn = (turn_count_reg == '0) ? '0 : TW'(turn_count_reg - CW'(1));

    assign store  = (mode == MODE_PLAY) && btn_select && (state_reg != FULL);
    assign browse = (mode == MODE_HIST) && (state_reg != EMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= EMPTY;
            turn_count_reg    <= '0;
            selected_turn_reg <= '0;
            last_turn_reg     <= 1'b0;
            full_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            turn_count_reg    <= turn_count_next;
            selected_turn_reg <= selected_turn_next;
            last_turn_reg     <= (turn_count_next == CW'(TURNS - 1));
            full_reg          <= (turn_count_next == CW'(TURNS));
        end
    end

    always_comb begin
        state_next         = state_reg;
        turn_count_next    = turn_count_reg;
        selected_turn_next = selected_turn_reg;

        if (store) begin
            turn_count_next = turn_count_reg + CW'(1);
        end

        case (state_reg)
            EMPTY: if (store) state_next = (turn_count_next == CW'(TURNS)) ? FULL : PLAY;
            PLAY:  if (store && (turn_count_next == CW'(TURNS))) state_next = FULL;
            FULL:  state_next = FULL;
            default: state_next = EMPTY;
        endcase

        if (store) begin
            // Point at the slot being written; it is the newest turn from now on.
            selected_turn_next = TW'(turn_count_reg);
        end else if (mode == MODE_PLAY) begin
            selected_turn_next = newest_turn;
        end else if (browse) begin
            // Simultaneous up and down cancel out.
            if (btn_up && !btn_down && (selected_turn_reg < newest_turn)) begin
                selected_turn_next = selected_turn_reg + TW'(1);
            end else if (btn_down && !btn_up && (selected_turn_reg != '0)) begin
                selected_turn_next = selected_turn_reg - TW'(1);
            end
        end
    end

`ifdef MM_HISTORY_SCORE_EN
    assign wr_data = {score_white, score_black, guess};
`else
    assign wr_data = guess;
`endif

    mm_history_ram #(
        .DEPTH (TURNS),
        .WIDTH (DW),
        .AW    (TW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (store),
        .waddr   (TW'(turn_count_reg)),
        .wdata   (wr_data),
        .raddr   (selected_turn_reg),
        .rd_zero (turn_count_reg == '0),
        .rdata   (rd_data)
    );

    assign selection     = rd_data[GW-1:0];
`ifdef MM_HISTORY_SCORE_EN
    assign sel_black     = rd_data[GW +: SW];
    assign sel_white     = rd_data[GW+SW +: SW];
`endif
    assign selected_turn = selected_turn_reg;
    assign turn_count    = turn_count_reg;
    assign last_turn     = last_turn_reg && (mode == MODE_PLAY);
    assign full          = full_reg;

endmodule

// File: tb/tb_mm_guess_history.sv
module tb_mm_guess_history;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        btn_select = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic [11:0] guess = '0;
    logic [11:0] selection;
    logic [2:0]  selected_turn;
    logic [3:0]  turn_count;
    logic        last_turn;
    logic        full;
`ifdef MM_HISTORY_SCORE_EN
    logic [2:0]  score_black = '0;
    logic [2:0]  score_white = '0;
    logic [2:0]  sel_black;
    logic [2:0]  sel_white;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mm_guess_history dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .btn_select    (btn_select),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .guess         (guess),
`ifdef MM_HISTORY_SCORE_EN
        .score_black   (score_black),
        .score_white   (score_white),
        .sel_black     (sel_black),
        .sel_white     (sel_white),
`endif
        .selection     (selection),
        .selected_turn (selected_turn),
        .turn_count    (turn_count),
        .last_turn     (last_turn),
        .full          (full)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        reset = 1'b1;
        mode = 1'b0; btn_select = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("reset");
    endtask

    task automatic store(input logic [11:0] g);
        mode = 1'b0; guess = g; btn_select = 1'b1;
        @(negedge clk);
        btn_select = 1'b0;
        $display("store guess=%h count=%0d sel_turn=%0d", g, turn_count, selected_turn);
    endtask

    task automatic press(input logic up, input logic down);
        btn_up = up; btn_down = down;
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0;
        $display("press up=%0b down=%0b sel_turn=%0d selection=%h", up, down, selected_turn, selection);
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (selection !== 12'h000) begin bad++; $display("FAIL reset_selection got=%h exp=%h", selection, 12'h000); end
        total++; if (turn_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", turn_count); end
        total++; if ({last_turn, full} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {last_turn, full}); end
        mode = 1'b1;
        press(1'b1, 1'b0);
        idle();
        total++; if (selected_turn !== 3'd0) begin bad++; $display("FAIL empty_up_turn got=%0d exp=0", selected_turn); end
        total++; if (selection !== 12'h000) begin bad++; $display("FAIL empty_up_selection got=%h exp=000", selection); end
        total++; if (turn_count !== 4'd0) begin bad++; $display("FAIL empty_up_count got=%0d exp=0", turn_count); end
        mode = 1'b0;
    endtask

    task automatic test_store();
        do_reset();
        store(12'h123);
        store(12'h456);
        store(12'h789);
        // Read for the last store still points at turn 1 on that edge.
        total++; if (selection !== 12'h456) begin bad++; $display("FAIL store_latency got=%h exp=456", selection); end
        idle();
        total++; if (turn_count !== 4'd3) begin bad++; $display("FAIL store_count got=%0d exp=3", turn_count); end
        total++; if (selected_turn !== 3'd2) begin bad++; $display("FAIL store_turn got=%0d exp=2", selected_turn); end
        total++; if (selection !== 12'h789) begin bad++; $display("FAIL store_selection got=%h exp=789", selection); end
    endtask

    task automatic test_browse();
        logic [2:0]  exp_turn_dn [3] = '{3'd1, 3'd0, 3'd0};
        logic [11:0] exp_sel_dn  [3] = '{12'h789, 12'h456, 12'h123};
        logic [2:0]  exp_turn_up [5] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
        logic [11:0] exp_sel_up  [5] = '{12'h123, 12'h456, 12'h789, 12'h789, 12'h789};
        test_store();
        mode = 1'b1;
        idle();
        total++; if (selected_turn !== 3'd2) begin bad++; $display("FAIL hist_entry_turn got=%0d exp=2", selected_turn); end
        for (int i = 0; i < 3; i++) begin
            press(1'b0, 1'b1);
            total++; if (selected_turn !== exp_turn_dn[i]) begin bad++; $display("FAIL down%0d_turn got=%0d exp=%0d", i, selected_turn, exp_turn_dn[i]); end
            total++; if (selection !== exp_sel_dn[i]) begin bad++; $display("FAIL down%0d_selection got=%h exp=%h", i, selection, exp_sel_dn[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0);
            total++; if (selected_turn !== exp_turn_up[i]) begin bad++; $display("FAIL up%0d_turn got=%0d exp=%0d", i, selected_turn, exp_turn_up[i]); end
            total++; if (selection !== exp_sel_up[i]) begin bad++; $display("FAIL up%0d_selection got=%h exp=%h", i, selection, exp_sel_up[i]); end
        end
        press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        total++; if (selected_turn !== 3'd1) begin bad++; $display("FAIL up_down_turn got=%0d exp=1", selected_turn); end
        // Select in history mode must not store.
        btn_select = 1'b1; guess = 12'hfff;
        idle();
        btn_select = 1'b0;
        total++; if (turn_count !== 4'd3) begin bad++; $display("FAIL hist_select_count got=%0d exp=3", turn_count); end
        // Up/down in play mode are ignored; turn tracks newest.
        mode = 1'b0;
        press(1'b0, 1'b1);
        idle();
        total++; if (selected_turn !== 3'd2) begin bad++; $display("FAIL play_down_turn got=%0d exp=2", selected_turn); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++) store(12'h100 + 12'(i));
        total++; if (last_turn !== 1'b1) begin bad++; $display("FAIL last_turn7 got=%b exp=1", last_turn); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full7 got=%b exp=0", full); end
        mode = 1'b1;
        idle();
        total++; if (last_turn !== 1'b0) begin bad++; $display("FAIL last_turn_hist got=%b exp=0", last_turn); end
        store(12'h107);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full8 got=%b exp=1", full); end
        total++; if (last_turn !== 1'b0) begin bad++; $display("FAIL last_turn8 got=%b exp=0", last_turn); end
        total++; if (turn_count !== 4'd8) begin bad++; $display("FAIL count8 got=%0d exp=8", turn_count); end
        store(12'h5a5);
        idle();
        total++; if (turn_count !== 4'd8) begin bad++; $display("FAIL count9 got=%0d exp=8", turn_count); end
        total++; if (selected_turn !== 3'd7) begin bad++; $display("FAIL turn9 got=%0d exp=7", selected_turn); end
        total++; if (selection !== 12'h107) begin bad++; $display("FAIL entry7_kept got=%h exp=107", selection); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) store(12'h201 + 12'(i));
        idle();
        #2;
        reset = 1'b1;
        #1;
        total++; if ({selection, selected_turn, turn_count, last_turn, full} !== '0) begin
            bad++; $display("FAIL async_reset got sel=%h turn=%0d count=%0d lt=%b full=%b exp all 0",
                            selection, selected_turn, turn_count, last_turn, full);
        end
        @(negedge clk);
        reset = 1'b0;
        store(12'habc);
        idle();
        total++; if (turn_count !== 4'd1) begin bad++; $display("FAIL post_reset_count got=%0d exp=1", turn_count); end
        total++; if (selected_turn !== 3'd0) begin bad++; $display("FAIL post_reset_turn got=%0d exp=0", selected_turn); end
        total++; if (selection !== 12'habc) begin bad++; $display("FAIL post_reset_selection got=%h exp=abc", selection); end
    endtask

`ifdef MM_HISTORY_SCORE_EN
    task automatic test_score();
        do_reset();
        score_black = 3'd2; score_white = 3'd1;
        store(12'h321);
        score_black = 3'd0; score_white = 3'd3;
        store(12'h654);
        mode = 1'b1;
        idle();
        total++; if ({selection, sel_black, sel_white} !== {12'h654, 3'd0, 3'd3}) begin
            bad++; $display("FAIL score_newest got=%h/%0d/%0d exp=654/0/3", selection, sel_black, sel_white);
        end
        press(1'b0, 1'b1);
        idle();
        total++; if ({selection, sel_black, sel_white} !== {12'h321, 3'd2, 3'd1}) begin
            bad++; $display("FAIL score_browse got=%h/%0d/%0d exp=321/2/1", selection, sel_black, sel_white);
        end
        mode = 1'b0;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_store();
        test_browse();
        test_full();
        test_async_reset();
`ifdef MM_HISTORY_SCORE_EN
        test_score();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
